// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one floating-point multiplier among NREQ requesters
// through a two-stage (operand, result) pipeline that stalls on consumer backpressure.

module fp_mul #(
  parameter  int unsigned MANTISSA = 9,
  localparam int unsigned WIDTH    = MANTISSA + 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);
  localparam int unsigned         PW       = 2 * (MANTISSA + 1);
  localparam logic [9:0]          BIAS     = 10'd127;
  localparam logic [9:0]          EOVF     = 10'd382;
  localparam logic [MANTISSA-1:0] NAN_FRAC = MANTISSA'(1) << (MANTISSA - 1);

  logic                sa, sb, sp;
  logic [7:0]          ea, eb, ep;
  logic [MANTISSA-1:0] fa, fb, fp;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, norm;
  logic [PW-1:0]       prod;
  logic [9:0]          esum;
  logic                unused_low_bits;

  // Subnormal inputs and underflowing results flush to zero; fraction truncates.
  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);
    prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});
    norm   = prod[PW-1];
    fp     = norm ? prod[PW-2 -: MANTISSA] : prod[PW-3 -: MANTISSA];
    esum   = 10'(ea) + 10'(eb) + 10'(norm);
    ep     = 8'(esum - BIAS);
    sp     = sa ^ sb;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p = {1'b1, 8'hFF, NAN_FRAC};
    end else if (a_inf || b_inf) begin
      p = {sp, 8'hFF, {MANTISSA{1'b0}}};
    end else if (a_zero || b_zero || (esum <= BIAS)) begin
      p = {sp, 8'h00, {MANTISSA{1'b0}}};
    end else if (esum >= EOVF) begin
      p = {sp, 8'hFF, {MANTISSA{1'b0}}};
    end else begin
      p = {sp, ep, fp};
    end
  end

  assign unused_low_bits = ^prod[PW-MANTISSA-3:0];

endmodule

module fp_mul_arbiter #(
  parameter  int unsigned MANTISSA = 9,
  parameter  int unsigned NREQ     = 4,
  localparam int unsigned WIDTH    = MANTISSA + 9,
  localparam int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic                  busy
);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic             v0, v1;
  logic [WIDTH-1:0] a0, b0, data1;
  logic [IDW-1:0]   id0, id1, ptr;

  logic             adv0, adv1, gnt_any, xfer;
  logic [IDW-1:0]   gnt_idx, ptr_nxt;
  logic [NREQ-1:0]  below_ptr, upper, pick;
  logic [WIDTH-1:0] sel_a, sel_b, prod;

  fp_mul #(.MANTISSA(MANTISSA)) u_mul (
    .a (a0),
    .b (b0),
    .p (prod)
  );

  // Round-robin: prefer the lowest valid index at or above ptr, else wrap to the lowest.
  always_comb begin
    below_ptr = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      below_ptr[i] = (IDW'(i) < ptr);
    end
    upper   = req_valid & ~below_ptr;
    pick    = (|upper) ? upper : req_valid;
    gnt_any = |req_valid;
    gnt_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (pick[i]) gnt_idx = IDW'(i);
    end
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    adv1      = !v1 || res_ready;
    adv0      = !v0 || adv1;
    xfer      = adv0 && gnt_any;
    req_ready = (xfer && !reset) ? (NREQ'(1) << gnt_idx) : '0;
    ptr_nxt   = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      a0    <= '0;
      b0    <= '0;
      id0   <= '0;
      data1 <= '0;
      id1   <= '0;
      ptr   <= '0;
    end else begin
      if (adv1) begin
        v1    <= v0;
        data1 <= prod;
        id1   <= id0;
      end
      if (adv0) begin
        v0 <= gnt_any;
        if (gnt_any) begin
          a0  <= sel_a;
          b0  <= sel_b;
          id0 <= gnt_idx;
          ptr <= ptr_nxt;
        end
      end
    end
  end

  assign res_valid = v1;
  assign res_data  = data1;
  assign res_id    = id1;
  assign busy      = v0 || v1;

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one floating-point multiplier between NREQ requesters, such as the vector lanes and the reduction unit. It round-robin arbitrates among valid requests and issues one product per cycle into a two-stage pipeline: an operand register, the combinational multiply, then a result register. It returns each result tagged with the requester ID, and backpressure from the consumer stalls the whole pipeline.

## Interface
- MANTISSA, 9, fraction bits of the operand format; exponent fixed at 8; WIDTH = MANTISSA+9 (18 for the default format)
- NREQ, 4, number of requesters, ≥1; IDW = max(1, clog2(NREQ))
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i presents operands
- req_a  in  NREQ*WIDTH  operand A of requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_ready  out  NREQ  one-hot (or zero) grant; a transfer occurs when req_valid[i] && req_ready[i]
- res_valid  out  1  result register holds a product
- res_data  out  WIDTH  product; flush-to-zero, truncating, NaN = {1, all-ones exp, 1, zeros}
- res_id  out  IDW  requester index of res_data
- res_ready  in  1  consumer accepts result this cycle
- busy  out  1  either pipeline stage holds a valid entry

## Operation
- Stages: S0 holds {v0, a0, b0, id0}; S1 holds {v1, data1, id1}. The multiply is combinational between S0 and S1 and instantiated internally with the same MANTISSA.
- Stall rule: adv1 = !v1 || res_ready; adv0 = !v0 || adv1.
- When adv1: v1 <= v0, data1 <= mul(a0, b0), id1 <= id0. When !adv1, S1 holds.
- When adv0: S0 loads the granted request, or v0 <= 0 if nothing is granted. When !adv0, S0 holds.
- Arbitration: pointer ptr (IDW bits). Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … modulo NREQ.
- req_ready[i] = adv0 && (i == granted index). It depends combinationally on req_valid; requesters must not make valid depend on ready.
- After a transfer from i: ptr <= (i+1) mod NREQ. The wrap from NREQ-1 goes to 0, and non-power-of-two NREQ must wrap correctly. ptr is unchanged on cycles without a transfer.
- Operand and data registers do not change while their stage is stalled. Their contents are don't-care when the valid bit is 0.
- res_valid = v1; res_data = data1; res_id = id1; busy = v0 || v1.
- NREQ = 1: ptr is constant 0; grant is req_valid[0] && adv0.

## Timing
- Reset (async assert, sync release): v0 = v1 = 0, ptr = 0. Hence res_valid = 0, busy = 0, req_ready = 0 while reset is high. res_data and res_id reset to 0.
- Latency: a request accepted at edge k appears on res_valid/res_data after edge k+1, i.e. two cycles from presentation to result.
- Throughput: 1 result/cycle with res_ready held high.
- Full pipeline (v0 = v1 = 1) with res_ready = 0: req_ready = 0, nothing changes.
- On the cycle res_ready rises with a full pipeline, S1 takes S0 and S0 takes a new grant in the same edge, so there are no bubbles.
- Result accept and new issue in the same cycle are always allowed when adv0 holds.
- Reset mid-operation: in-flight entries are discarded, with no result emitted for them, and ptr returns to 0.

## Test plan
- Single op, MANTISSA=9: requester 2 only, a=0x0FF00 (1.5), b=0x0FF00 -> req_ready=0b0100 in cycle 0; res_valid=1, res_data=0x10040 (2.25), res_id=2 two cycles later; busy falls afterwards.
- Round-robin: all four req_valid held high, res_ready=1 -> grants 0,1,2,3,0,1… one per cycle; res_id follows the same sequence, lagging two cycles; res_data 0x0FE00*0x10000 = 0x10000.
- Backpressure: stream of 6 requests, res_ready=0 for 3 cycles mid-stream -> res_data/res_id held stable while stalled, req_ready=0 once both stages are full, no loss or duplication, order preserved.
- Special values: inf*0 (0x1FE00, 0x00000) -> 0x3FF00; inf*2.0 -> 0x1FE00; 0x00123 (subnormal) * 1.0 -> 0x00000.
- Pointer skip/wrap (NREQ=3 build): only requesters 0 and 2 valid, starting ptr=0 -> grants 0,2,0,2; ptr wraps 2→0.
- Reset mid-stream: assert reset with v0 = v1 = 1 -> res_valid, busy, req_ready drop immediately and asynchronously; after release, first grant goes to requester 0.
